// File: rtl/not_gate_bist.sv
// Built-in self-test for a WIDTH-lane inverter: drives index-derived vectors and checks dut_out == ~dut_in.
// Optional macro BIST_ERRCNT_EN adds a saturating 8-bit mismatch counter on port err_count.
module not_gate_bist #(
  parameter int WIDTH         = 1,
  parameter int NUM_VECTORS   = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass
`ifdef BIST_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] LAST_IDX    = 8'(NUM_VECTORS - 1);
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  state_t     state, state_nxt;
  logic [7:0] idx;
  logic [7:0] idx_inc;
  logic [3:0] settle_cnt;
  logic       fail;
  logic       mismatch;
  logic       last_vec;
  logic       run_start;

  assign mismatch  = (state == SAMPLE) && (dut_out != ~dut_in);
  assign last_vec  = (idx == LAST_IDX);
  assign idx_inc   = idx + 8'd1;
  assign run_start = ((state == IDLE) || (state == DONE)) && start;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE;
      DRIVE:      state_nxt = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
      SETTLE:     if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = last_vec ? DONE : DRIVE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      idx        <= '0;
      settle_cnt <= '0;
      fail       <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == DRIVE) || (state_nxt == SETTLE) || (state_nxt == SAMPLE);
      done  <= (state_nxt == DONE);
      pass  <= (state_nxt == DONE) && !(fail || mismatch);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx    <= '0;
            dut_in <= '0;
            fail   <= 1'b0;
          end
        end
        DRIVE:  settle_cnt <= '0;
        SETTLE: settle_cnt <= settle_cnt + 4'd1;
        SAMPLE: begin
          if (mismatch) fail <= 1'b1;
          if (!last_vec) begin
            idx    <= idx_inc;
            dut_in <= WIDTH'(idx_inc);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIST_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst || run_start) begin
      err_count <= '0;
    end else if (mismatch && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_not_gate_bist.sv
// Bench for not_gate_bist: two instances (default config and a wide zero-settle 256-vector config)
// exercised by a timing/response reference model with randomized fault injection.
module tb_not_gate_bist;

  localparam int W_A = 1, N_A = 16,  S_A = 2;
  localparam int W_B = 3, N_B = 256, S_B = 0;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_a, start_b;
  logic [W_A-1:0] din_a, dout_a;
  logic [W_B-1:0] din_b, dout_b;
  logic           busy_a, done_a, pass_a;
  logic           busy_b, done_b, pass_b;
`ifdef BIST_ERRCNT_EN
  logic [7:0]     ec_a, ec_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  not_gate_bist #(.WIDTH(W_A), .NUM_VECTORS(N_A), .SETTLE_CYCLES(S_A)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_in(din_a), .dut_out(dout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a)
`ifdef BIST_ERRCNT_EN
    , .err_count(ec_a)
`endif
  );

  not_gate_bist #(.WIDTH(W_B), .NUM_VECTORS(N_B), .SETTLE_CYCLES(S_B)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_in(din_b), .dut_out(dout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b)
`ifdef BIST_ERRCNT_EN
    , .err_count(ec_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  task automatic set_dout(input int sel, input logic [7:0] v);
    if (sel == 0) dout_a = v[W_A-1:0]; else dout_b = v[W_B-1:0];
  endtask

  task automatic check_outs(input string tag, input int sel, input logic b, input logic d,
                            input logic p, input logic [7:0] vin);
    check({tag, "_busy"}, 32'(sel ? busy_b : busy_a), 32'(b));
    check({tag, "_done"}, 32'(sel ? done_b : done_a), 32'(d));
    check({tag, "_pass"}, 32'(sel ? pass_b : pass_a), 32'(p));
    check({tag, "_din"},  sel ? 32'(din_b) : 32'(din_a), 32'(vin));
  endtask

  // mode: 0 good inverter, 1 stuck-at-0, 2 stuck-at-1, 3 random lane flips, 4 buffer (always wrong)
  task automatic run(input int sel, input int mode, input bit hold);
    int         w, n, s, per, errs, k;
    logic [7:0] mask, vec, resp, good;
    w    = sel ? W_B : W_A;
    n    = sel ? N_B : N_A;
    s    = sel ? S_B : S_A;
    per  = s + 2;
    errs = 0;
    mask = 8'((1 << w) - 1);
    @(negedge clk);
    set_start(sel, 1'b1);
    for (int e = 1; e <= n * per; e++) begin
      @(posedge clk);
      @(negedge clk);
      check("run_busy", 32'(sel ? busy_b : busy_a), 32'd1);
      check("run_done", 32'(sel ? done_b : done_a), 32'd0);
      set_start(sel, hold ? 1'b1 : ((mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0));
      if (e % per == 0) begin
        k    = e / per - 1;
        vec  = 8'(k) & mask;
        good = ~vec & mask;
        check("run_vec", sel ? 32'(din_b) : 32'(din_a), 32'(vec));
        case (mode)
          0:       resp = good;
          1:       resp = 8'h00;
          2:       resp = mask;
          3:       resp = ($urandom_range(0, 3) == 0) ? (good ^ 8'(1 << $urandom_range(0, w - 1))) : good;
          default: resp = vec;
        endcase
        if (((resp ^ good) & mask) != 8'h00) errs++;
        set_dout(sel, resp);
      end else begin
        set_dout(sel, 8'($urandom));
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) set_start(sel, 1'b0);
    check_outs("end", sel, 1'b0, 1'b1, (errs == 0), 8'(n - 1) & mask);
`ifdef BIST_ERRCNT_EN
    check("end_errcnt", 32'(sel ? ec_b : ec_a), (errs > 255) ? 32'd255 : 32'(errs));
`endif
    // The held result must stay put while start is low.
    if (!hold) begin
      repeat (3) @(negedge clk);
      check_outs("hold", sel, 1'b0, 1'b1, (errs == 0), 8'(n - 1) & mask);
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1; dout_a = '0; dout_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("rst_a", 0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_outs("rst_b", 1, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef BIST_ERRCNT_EN
    check("rst_ec_a", 32'(ec_a), 32'd0);
`endif
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("idle_a", 0, 1'b0, 1'b0, 1'b0, 8'h00);

    run(0, 0, 1'b0);
    run(0, 1, 1'b0);
    run(0, 2, 1'b0);
    run(0, 3, 1'b0);
    run(0, 3, 1'b0);
    run(0, 4, 1'b0);
    run(0, 0, 1'b0);
    run(1, 0, 1'b0);
    run(1, 2, 1'b0);
    run(1, 3, 1'b0);
    run(1, 4, 1'b0);
    run(1, 1, 1'b0);

    // Start held high: one complete run, then a fresh run begins straight from DONE.
    run(0, 0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_outs("restart", 0, 1'b1, 1'b0, 1'b0, 8'h00);
    start_a = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outs("abort", 0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check_outs("no_done", 0, 1'b0, 1'b0, 1'b0, 8'h00);

    run(0, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/not_gate_bist.md
NOT_GATE_BIST -- requirements
Module: not_gate_bist

Interface
REQ-001 Parameter WIDTH, default 1, number of parallel inverter lanes driven and checked.
REQ-002 Parameter NUM_VECTORS, default 16, vectors per run; legal range 1..256.
REQ-003 Parameter SETTLE_CYCLES, default 2, wait cycles between driving a vector and sampling; legal range 0..15.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: start  input  1  level-sampled run request.
REQ-008 Port: dut_in  output  WIDTH  stimulus to the inverter under test; registered.
REQ-009 Port: dut_out  input  WIDTH  response from the inverter under test.
REQ-010 Port: busy  output  1  high while a run is in progress.
REQ-011 Port: done  output  1  high while the result is held, until the next run starts.
REQ-012 Port: pass  output  1  valid when done=1; 1 when no mismatch occurred.

Function
REQ-013 FSM states IDLE, DRIVE, SETTLE, SAMPLE, DONE; all outputs are registered.
REQ-014 IDLE or DONE with start=1 at an edge: go to DRIVE, vector index <= 0, dut_in <= 0, fail flag cleared, error counter cleared.
REQ-015 start=1 in DRIVE, SETTLE or SAMPLE is ignored.
REQ-016 DRIVE lasts exactly 1 cycle; then SETTLE if SETTLE_CYCLES>0, else SAMPLE.
REQ-017 SETTLE lasts exactly SETTLE_CYCLES cycles, then SAMPLE.
REQ-018 SAMPLE lasts 1 cycle; a mismatch is dut_out != ~dut_in on any lane; a mismatch sets the sticky fail flag.
REQ-019 At the end of SAMPLE, if index == NUM_VECTORS-1, go to DONE; otherwise index <= index+1, dut_in <= (index+1) truncated to WIDTH bits, go to DRIVE.
REQ-020 Vector value is the low WIDTH bits of the index; for WIDTH=1 the stimulus alternates 0,1,0,1...
REQ-021 Each vector takes SETTLE_CYCLES+2 cycles; done rises NUM_VECTORS*(SETTLE_CYCLES+2) edges after the start-capturing edge.
REQ-022 busy=1 in DRIVE, SETTLE and SAMPLE; done=1 only in DONE; pass = ~fail flag while done=1, else 0.
REQ-023 dut_in holds its last vector in DONE and is not changed until the next run.
REQ-024 dut_out is sampled only in SAMPLE; its value in every other state is ignored.

Reset
REQ-025 rst=1 at an edge: state <= IDLE, dut_in <= 0, busy <= 0, done <= 0, pass <= 0, index <= 0, fail flag <= 0, err_count <= 0.
REQ-026 Reset takes priority over start and over any in-progress run.
REQ-027 Reset mid-run aborts without asserting done; a new start is required.

Configuration
REQ-028 Macro BIST_ERRCNT_EN defined: adds output port err_count, 8 bits, counting SAMPLE cycles with a mismatch; saturates at 255; cleared at run start and on reset; valid when done=1.
REQ-029 Macro BIST_ERRCNT_EN undefined: err_count port and counter are absent; all other behaviour is identical.

Verification
REQ-030 Correct inverter model, NUM_VECTORS=16, SETTLE_CYCLES=2, 1-cycle start pulse -> busy for 64 cycles, then done=1, pass=1, err_count=0.
REQ-031 dut_out stuck at 0, WIDTH=1, defaults -> done after 64 cycles, pass=0, err_count=8 (mismatches on the even vectors).
REQ-032 SETTLE_CYCLES=0, correct model -> done rises 32 edges after start, pass=1; no SETTLE state is visited.
REQ-033 start held high for the whole run -> exactly one run, done at edge 64; after that a new run starts from DONE on the next edge, clearing done.
REQ-034 rst asserted at cycle 20 of a run -> next cycle busy=0, done=0, dut_in=0; no done without a new start.
REQ-035 Stuck-at-1 model, BIST_ERRCNT_EN defined, NUM_VECTORS=256 -> pass=0, err_count=128.
